// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared states, opcodes and instruction field layout for alu_issue_ctrl
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] OPC_AND  = 4'b0000;
  localparam logic [3:0] OPC_SHL  = 4'b0001;
  localparam logic [3:0] OPC_OR   = 4'b0010;
  localparam logic [3:0] OPC_XOR  = 4'b0011;
  localparam logic [3:0] OPC_ADD  = 4'b0100;
  localparam logic [3:0] OPC_ADDI = 4'b0101;
  localparam logic [3:0] OPC_SHR  = 4'b0110;
  localparam logic [3:0] OPC_MUL  = 4'b0111;
  localparam logic [3:0] OPC_LDI  = 4'b1000;
  localparam logic [3:0] OPC_SUB  = 4'b1100;
  localparam logic [3:0] OPC_SUBI = 4'b1101;

  // Instruction layout: [15:12] opc, [11:10] rd, [9:8] rs, [7:6] rt, [5:0] imm
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int REG_AW  = 2;
  localparam int LDI_W   = 10;

  // Opcodes that are forwarded to the ALU as its control word
  function automatic logic is_alu_opc(input logic [3:0] opc);
    case (opc)
      OPC_AND, OPC_SHL, OPC_OR, OPC_XOR, OPC_ADD,
      OPC_ADDI, OPC_SHR, OPC_MUL, OPC_SUB, OPC_SUBI: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction, ALU and result channels of alu_issue_ctrl (res_zero under ALU_ISSUE_ZERO_FLAG_EN)
interface alu_issue_if;

  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;

  logic [3:0]  alu_vlera;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_rezultati;
  logic        alu_cout;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_rd;
  logic        res_cout;
  logic        res_err;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic        res_zero;
`endif

  // Issue controller side
  modport master (
    input  instr_valid, instr, alu_rezultati, alu_cout, res_ready,
    output instr_ready, alu_vlera, alu_a, alu_b,
    output res_valid, res_data, res_rd, res_cout, res_err
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    , output res_zero
`endif
  );

  // Instruction source, ALU and result sink side
  modport slave (
    output instr_valid, instr, alu_rezultati, alu_cout, res_ready,
    input  instr_ready, alu_vlera, alu_a, alu_b,
    input  res_valid, res_data, res_rd, res_cout, res_err
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    , input res_zero
`endif
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - REG_CNT x 16 register file, 2 async read ports, 1 sync write port
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int REG_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [15:0]       ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [15:0]       rb_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [15:0]       wr_data
);

  logic [15:0] regs [REG_CNT];

  // Write port; reset clears every register at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle ALU issue controller; ALU_ISSUE_ZERO_FLAG_EN adds res_zero
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int REG_CNT = 4,
  parameter int IMM_W   = 6
) (
  input  logic     clk,
  input  logic     reset,
  alu_issue_if.master bus
);

  state_t state, state_nx;
  logic   accept;
  logic   capture;

  logic [15:0]       instr_q;
  logic [3:0]        opc_in;
  logic [REG_AW-1:0] rs_in;
  logic [REG_AW-1:0] rt_in;
  logic [15:0]       imm_ext;
  logic [3:0]        opc_q;
  logic [REG_AW-1:0] rd_q;

  logic [REG_AW-1:0] rb_addr;
  logic [15:0]       ra_data;
  logic [15:0]       rb_data;
  logic              legal_alu_q;
  logic              is_ldi_q;
  logic              illegal_q;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic [15:0]       res_value;

  assign opc_in  = bus.instr[OPC_LSB +: OPC_W];
  assign rs_in   = bus.instr[RS_LSB +: REG_AW];
  assign rt_in   = bus.instr[RT_LSB +: REG_AW];
  assign imm_ext = {{(16 - IMM_W){1'b0}}, bus.instr[IMM_W-1:0]};
  assign opc_q   = instr_q[OPC_LSB +: OPC_W];
  assign rd_q    = instr_q[RD_LSB +: REG_AW];

  assign legal_alu_q = is_alu_opc(opc_q);
  assign is_ldi_q    = (opc_q == OPC_LDI);
  assign illegal_q   = !legal_alu_q && !is_ldi_q;

  // Port b reads rt while an instruction is offered, and rd during CAPT so an
  // illegal opcode can report the untouched destination value
  assign rb_addr = (state == CAPT) ? rd_q : rt_in;

  assign wr_data   = is_ldi_q ? {{(16 - LDI_W){1'b0}}, instr_q[LDI_W-1:0]} : bus.alu_rezultati;
  assign wr_en     = capture && !illegal_q;
  assign res_value = illegal_q ? rb_data : wr_data;

  alu_issue_regfile #(
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs_in),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .wr_en   (wr_en),
    .wr_addr (rd_q),
    .wr_data (wr_data)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, handshake outputs and per-state strobes
  always_comb begin
    state_nx        = state;
    accept          = 1'b0;
    capture         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.res_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = CAPT;
      CAPT: begin
        capture  = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are loaded on acceptance so they are already stable during EXEC
  // and held through CAPT while the ALU result is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q       <= '0;
      bus.alu_vlera <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
    end else if (accept) begin
      instr_q       <= bus.instr;
      bus.alu_vlera <= is_alu_opc(opc_in) ? opc_in : 4'b0000;
      bus.alu_a     <= ra_data;
      bus.alu_b     <= (opc_in == OPC_ADDI || opc_in == OPC_SUBI) ? imm_ext : rb_data;
    end
  end

  // Result registers load only in CAPT, so they stay put while RESP waits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.res_data <= '0;
      bus.res_rd   <= '0;
      bus.res_cout <= 1'b0;
      bus.res_err  <= 1'b0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      bus.res_zero <= 1'b0;
`endif
    end else if (capture) begin
      bus.res_data <= res_value;
      bus.res_rd   <= rd_q;
      bus.res_cout <= legal_alu_q && bus.alu_cout;
      bus.res_err  <= illegal_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      bus.res_zero <= !illegal_q && (wr_data == 16'h0000);
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with behavioural ALU
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  rd;
    logic        cout;
    logic        err;
    logic        zero;
    logic [3:0]  vlera;
    logic [15:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  logic [15:0] m_r [4];

  alu_issue_if bus ();

  alu_issue_ctrl #(
    .REG_CNT (4),
    .IMM_W   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 16-bit ALU: bit 3 negates b and injects carry-in
  always_comb begin
    logic [15:0] bb;
    logic [16:0] sum;
    bb  = bus.alu_vlera[3] ? ~bus.alu_b : bus.alu_b;
    sum = {1'b0, bus.alu_a} + {1'b0, bb} + {16'b0, bus.alu_vlera[3]};
    bus.alu_rezultati = '0;
    bus.alu_cout      = 1'b0;
    case (bus.alu_vlera[2:0])
      3'b000: bus.alu_rezultati = bus.alu_a & bb;
      3'b001: bus.alu_rezultati = bus.alu_a << 1;
      3'b010: bus.alu_rezultati = bus.alu_a | bb;
      3'b011: bus.alu_rezultati = bus.alu_a ^ bb;
      3'b100, 3'b101: begin
        bus.alu_rezultati = sum[15:0];
        bus.alu_cout      = sum[16];
      end
      3'b110: bus.alu_rezultati = bus.alu_a >> 1;
      default: bus.alu_rezultati = {8'b0, bus.alu_a[7:0]} * {8'b0, bb[7:0]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [1:0] rt,
                                     input logic [5:0] imm);
    return {opc, rd, rs, rt, imm};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [9:0] v);
    return {OPC_LDI, rd, v};
  endfunction

  // Reference semantics of one instruction; updates the register model
  task automatic predict(input logic [15:0] ins, output exp_t e);
    logic [3:0]  opc;
    logic [1:0]  rd;
    logic [15:0] a, b, imm;
    logic [16:0] s;
    opc = ins[15:12];
    rd  = ins[11:10];
    a   = m_r[ins[9:8]];
    b   = m_r[ins[7:6]];
    imm = {10'b0, ins[5:0]};
    s   = '0;
    e.rd = rd; e.a = a; e.err = 1'b0; e.cout = 1'b0; e.vlera = opc; e.data = '0;
    case (opc)
      OPC_AND:  e.data = a & b;
      OPC_SHL:  e.data = {a[14:0], 1'b0};
      OPC_OR:   e.data = a | b;
      OPC_XOR:  e.data = a ^ b;
      OPC_ADD:  begin s = {1'b0, a} + {1'b0, b};   e.data = s[15:0]; e.cout = s[16]; end
      OPC_ADDI: begin s = {1'b0, a} + {1'b0, imm}; e.data = s[15:0]; e.cout = s[16]; end
      OPC_SHR:  e.data = {1'b0, a[15:1]};
      OPC_MUL:  e.data = {8'b0, a[7:0]} * {8'b0, b[7:0]};
      OPC_SUB:  begin e.data = a - b;   e.cout = (a >= b);   end
      OPC_SUBI: begin e.data = a - imm; e.cout = (a >= imm); end
      OPC_LDI:  begin e.data = {6'b0, ins[9:0]}; e.vlera = 4'b0000; end
      default:  begin e.data = m_r[rd]; e.err = 1'b1; e.vlera = 4'b0000; end
    endcase
    e.zero = !e.err && (e.data == 16'h0000);
    if (!e.err) m_r[rd] = e.data;
  endtask

  // Issue one instruction, check EXEC drive and latency, then hold res_ready low for hold cycles
  task automatic run_op(input logic [15:0] ins, input int hold);
    exp_t e, got;
    int   n;
    predict(ins, e);
    sbq.push_back(e);
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("instr_ready_idle", {31'b0, bus.instr_ready}, 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("exec_vlera", {28'b0, bus.alu_vlera}, {28'b0, e.vlera});
    check("exec_alu_a", {16'b0, bus.alu_a}, {16'b0, e.a});
    n = 0;
    while (!bus.res_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, 32'd2);
    got = sbq.pop_front();
    check("res_data", {16'b0, bus.res_data}, {16'b0, got.data});
    check("res_rd", {30'b0, bus.res_rd}, {30'b0, got.rd});
    check("res_cout", {31'b0, bus.res_cout}, {31'b0, got.cout});
    check("res_err", {31'b0, bus.res_err}, {31'b0, got.err});
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check("res_zero", {31'b0, bus.res_zero}, {31'b0, got.zero});
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, bus.res_valid}, 32'd1);
      check("hold_ready", {31'b0, bus.instr_ready}, 32'd0);
      check("hold_data", {16'b0, bus.res_data}, {16'b0, got.data});
      check("hold_err", {31'b0, bus.res_err}, {31'b0, got.err});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("done_valid", {31'b0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.res_ready   = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
    check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("rst_vlera", {28'b0, bus.alu_vlera}, 32'd0);
    check("rst_alu_a", {16'b0, bus.alu_a}, 32'd0);
    check("rst_alu_b", {16'b0, bus.alu_b}, 32'd0);
    check("rst_res_data", {16'b0, bus.res_data}, 32'd0);
    check("rst_res_err", {31'b0, bus.res_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(ldi(2'd1, 10'h0FF), 0);
    run_op(ldi(2'd2, 10'h30F), 0);
    run_op(mk(OPC_AND, 2'd3, 2'd1, 2'd2, 6'd0), 0);

    run_op(ldi(2'd1, 10'h3FF), 0);
    run_op(mk(OPC_ADD, 2'd2, 2'd1, 2'd1, 6'd0), 0);
    run_op(mk(OPC_ADD, 2'd3, 2'd2, 2'd2, 6'd0), 0);
    for (int i = 0; i < 6; i++) run_op(mk(OPC_ADD, 2'd3, 2'd3, 2'd3, 6'd0), 0);

    run_op(ldi(2'd1, 10'd5), 0);
    run_op(ldi(2'd2, 10'd7), 0);
    run_op(mk(OPC_SUB, 2'd3, 2'd1, 2'd2, 6'd0), 0);
    run_op(mk(OPC_SUBI, 2'd1, 2'd1, 2'd0, 6'd3), 0);
    run_op(mk(OPC_ADDI, 2'd0, 2'd1, 2'd0, 6'h3F), 0);

    run_op(ldi(2'd1, 10'h312), 0);
    run_op(ldi(2'd2, 10'h010), 0);
    run_op(mk(OPC_MUL, 2'd3, 2'd1, 2'd2, 6'd0), 0);

    run_op(ldi(2'd1, 10'h200), 0);
    for (int i = 0; i < 6; i++) run_op(mk(OPC_SHL, 2'd1, 2'd1, 2'd0, 6'd0), 0);
    run_op(ldi(2'd2, 10'd1), 0);
    run_op(mk(OPC_OR, 2'd1, 2'd1, 2'd2, 6'd0), 0);
    run_op(mk(OPC_SHL, 2'd2, 2'd1, 2'd0, 6'd0), 0);
    run_op(mk(OPC_SHR, 2'd3, 2'd1, 2'd0, 6'd0), 2);

    run_op(mk(4'b1110, 2'd2, 2'd1, 2'd1, 6'd0), 5);
    run_op(mk(OPC_OR, 2'd3, 2'd2, 2'd2, 6'd0), 0);
    run_op(mk(4'b1001, 2'd1, 2'd0, 2'd0, 6'd0), 0);
    run_op(mk(OPC_XOR, 2'd0, 2'd1, 2'd1, 6'd0), 0);

    // Abort an ADD while it sits in CAPT
    run_op(ldi(2'd1, 10'h155), 0);
    bus.instr       = mk(OPC_ADD, 2'd2, 2'd1, 2'd1, 6'd0);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("abort_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
    check("abort_vlera", {28'b0, bus.alu_vlera}, 32'd0);
    check("abort_res_data", {16'b0, bus.res_data}, 32'd0);
    check("abort_res_rd", {30'b0, bus.res_rd}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) run_op(mk(OPC_OR, 2'(i), 2'(i), 2'(i), 6'd0), 0);

    run_op(ldi(2'd1, 10'h2A5), 0);
    run_op(mk(OPC_XOR, 2'd1, 2'd1, 2'd1, 6'd0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
